// File: rtl/addsub_arbiter.sv
// Round-robin front end that time-shares one 4-bit adder/subtractor among NREQ
// requesters and returns each result on a single tagged, back-pressured channel.

module addersubtractor (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       m,
   output logic [3:0] s,
   output logic       c,
   output logic       ovf
);
   logic [3:0] bb;
   logic [4:0] sum;

   // Subtract is a + ~b + 1, so the mode bit doubles as the carry-in.
   assign bb  = m ? ~b : b;
   assign sum = {1'b0, a} + {1'b0, bb} + {4'b0000, m};
   assign s   = sum[3:0];
   assign c   = sum[4];
   assign ovf = (a[3] == bb[3]) && (s[3] != a[3]);
endmodule

// state | meaning
// IDLE  | arbitrate; req_ready to the winner, operands latched on that edge
// EXEC  | shared unit evaluates latched operands; result registered
// RESP  | rsp_valid high, result held until rsp_ready
module addsub_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]   req_m,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_r,
   output logic              rsp_c,
   output logic              rsp_ovf
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  id_q;
   logic [3:0]      a_q;
   logic [3:0]      b_q;
   logic            m_q;

   logic [2*NREQ-1:0] dbl;
   logic [IDW:0]      offs;
   logic [IDW:0]      sum;
   logic [IDW:0]      diff;
   logic [IDW:0]      nxt;
   logic [IDW-1:0]    gnt;
   logic [IDW-1:0]    ptr_nxt;
   logic              gnt_any;
   logic [3:0]        sel_a;
   logic [3:0]        sel_b;
   logic              sel_m;

   logic [3:0] s;
   logic       c;
   logic       ovf;

   // Rotate the valid vector so bit 0 is the requester at rr_ptr; lowest set bit wins.
   always_comb begin
      dbl     = {req_valid, req_valid} >> rr_ptr;
      gnt_any = 1'b0;
      offs    = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (dbl[k]) begin
            gnt_any = 1'b1;
            offs    = (IDW+1)'(k);
         end
      end
      sum     = {1'b0, rr_ptr} + offs;
      diff    = sum - NREQ_W;
      gnt     = (sum >= NREQ_W) ? diff[IDW-1:0] : sum[IDW-1:0];
      nxt     = {1'b0, gnt} + (IDW+1)'(1);
      ptr_nxt = (nxt == NREQ_W) ? '0 : nxt[IDW-1:0];
   end

   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_m     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt == IDW'(k)) begin
            req_ready[k] = (state == IDLE) && !rst && gnt_any;
            sel_a        = req_a[4*k +: 4];
            sel_b        = req_b[4*k +: 4];
            sel_m        = req_m[k];
         end
      end
   end

   addersubtractor u_addsub (
      .a   (a_q),
      .b   (b_q),
      .m   (m_q),
      .s   (s),
      .c   (c),
      .ovf (ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         m_q       <= 1'b0;
         id_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_r     <= '0;
         rsp_c     <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  a_q    <= sel_a;
                  b_q    <= sel_b;
                  m_q    <= sel_m;
                  id_q   <= gnt;
                  rr_ptr <= ptr_nxt;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_r     <= s;
               rsp_c     <= c;
               rsp_ovf   <= ovf;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed arithmetic, round-robin order, back-pressure,
// reset in flight, and random ops checked against a plain-arithmetic model.

module tb_addsub_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int RW   = IDW + 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_m;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_r;
   logic              rsp_c;
   logic              rsp_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_m     (req_m),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_r     (rsp_r),
      .rsp_c     (rsp_c),
      .rsp_ovf   (rsp_ovf)
   );

   // Reference: unsigned sum/difference for r and c, signed range test for ovf.
   function automatic logic [RW-1:0] exp_rsp(input int id, input logic [3:0] a,
                                             input logic [3:0] b, input logic m);
      int ua, ub, sa, sb, res, sres;
      logic c;
      logic v;
      logic [3:0] r;
      ua = int'(a);
      ub = int'(b);
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      if (m) begin
         res  = ua - ub;
         c    = (ua >= ub);
         sres = sa - sb;
      end else begin
         res  = ua + ub;
         c    = (res > 15);
         sres = sa + sb;
      end
      r = 4'(res & 15);
      v = (sres > 7) || (sres < -8);
      return {IDW'(id), r, c, v};
   endfunction

   function automatic int model_pick(input int ptr, input logic [NREQ-1:0] v);
      int i;
      for (int k = 0; k < NREQ; k++) begin
         i = (ptr + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [RW-1:0] got_rsp();
      return {rsp_id, rsp_r, rsp_c, rsp_ovf};
   endfunction

   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic m);
      req_a[4*i +: 4] = a;
      req_b[4*i +: 4] = b;
      req_m[i]        = m;
      req_valid[i]    = 1'b1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (rsp_valid) break;
      end
   endtask

   // Issue one request with rsp_ready high; entered and left 1 time unit after a rising edge in IDLE.
   task automatic do_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic m,
                        output int wait_cyc, output int lat, output logic [RW-1:0] res);
      set_req(i, a, b, m);
      rsp_ready = 1'b1;
      wait_cyc  = 0;
      while (wait_cyc < 20) begin
         @(negedge clk);
         if (req_ready[i]) break;
         wait_cyc++;
      end
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      wait_rsp(lat);
      res = rsp_valid ? got_rsp() : 'x;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '1;
      req_a     = 16'h5a3c;
      req_b     = 16'h1234;
      req_m     = 4'b1010;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0) $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
      else n_pass++;
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      else n_pass++;
      n_checks++;
      if (got_rsp() !== '0) $display("FAIL reset_rsp_data: got %h expected 0", got_rsp());
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0)
         $display("FAIL idle_no_req: got ready=%b valid=%b expected 0000/0", req_ready, rsp_valid);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      int w, l;
      logic [RW-1:0] res;
      do_op(0, 4'd5, 4'd3, 1'b0, w, l, res);
      n_checks++;
      if (w !== 0) $display("FAIL add_grant_wait: got %0d expected 0", w);
      else n_pass++;
      n_checks++;
      if (l !== 2) $display("FAIL add_latency: got %0d expected 2", l);
      else n_pass++;
      n_checks++;
      if (res !== {2'd0, 4'd8, 1'b0, 1'b1}) $display("FAIL add_5_3: got %h expected %h", res, {2'd0, 4'd8, 1'b0, 1'b1});
      else n_pass++;
   endtask

   task automatic test_sub();
      int w, l;
      logic [RW-1:0] res;
      do_op(2, 4'd5, 4'd3, 1'b1, w, l, res);
      n_checks++;
      if (res !== {2'd2, 4'd2, 1'b1, 1'b0}) $display("FAIL sub_5_3: got %h expected %h", res, {2'd2, 4'd2, 1'b1, 1'b0});
      else n_pass++;
      do_op(2, 4'd3, 4'd5, 1'b1, w, l, res);
      n_checks++;
      if (res !== {2'd2, 4'hE, 1'b0, 1'b0}) $display("FAIL sub_3_5: got %h expected %h", res, {2'd2, 4'hE, 1'b0, 1'b0});
      else n_pass++;
      do_op(2, 4'd8, 4'd1, 1'b1, w, l, res);
      n_checks++;
      if (res !== {2'd2, 4'd7, 1'b1, 1'b1}) $display("FAIL sub_8_1: got %h expected %h", res, {2'd2, 4'd7, 1'b1, 1'b1});
      else n_pass++;
   endtask

   task automatic test_wrap();
      int w, l;
      logic [RW-1:0] res;
      do_op(3, 4'd15, 4'd1, 1'b0, w, l, res);
      n_checks++;
      if (res !== {2'd3, 4'd0, 1'b1, 1'b0}) $display("FAIL wrap_15_1: got %h expected %h", res, {2'd3, 4'd0, 1'b1, 1'b0});
      else n_pass++;
      do_op(1, 4'd7, 4'd1, 1'b0, w, l, res);
      n_checks++;
      if (res !== {2'd1, 4'd8, 1'b0, 1'b1}) $display("FAIL wrap_7_1: got %h expected %h", res, {2'd1, 4'd8, 1'b0, 1'b1});
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [3:0] op_a [NREQ];
      logic [3:0] op_b [NREQ];
      logic       op_m [NREQ];
      logic [NREQ-1:0] exp_rdy;
      logic [RW-1:0] exp;
      int q[$];
      int ptr, last, ngr, cyc, g, id;
      pulse_reset();
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = 4'($urandom_range(0, 15));
         op_b[i] = 4'($urandom_range(0, 15));
         op_m[i] = 1'($urandom_range(0, 1));
         set_req(i, op_a[i], op_b[i], op_m[i]);
      end
      rsp_ready = 1'b1;
      ptr = 0; last = -1; ngr = 0; cyc = 0;
      while (ngr < 10 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) begin
            id  = (q.size() > 0) ? q.pop_front() : 0;
            exp = exp_rsp(id, op_a[id], op_b[id], op_m[id]);
            n_checks++;
            if (got_rsp() !== exp) $display("FAIL rr_response: got %h expected %h", got_rsp(), exp);
            else n_pass++;
         end
         if (req_ready != '0) begin
            g = model_pick(ptr, req_valid);
            exp_rdy = '0;
            exp_rdy[g] = 1'b1;
            n_checks++;
            if (req_ready !== exp_rdy) $display("FAIL rr_grant_%0d: got %b expected %b", ngr, req_ready, exp_rdy);
            else n_pass++;
            if (last >= 0) begin
               n_checks++;
               if (cyc - last !== 3) $display("FAIL rr_spacing: got %0d expected 3", cyc - last);
               else n_pass++;
            end
            last = cyc;
            ptr  = (g + 1) % NREQ;
            q.push_back(g);
            ngr++;
            if (ngr == 5) begin
               @(posedge clk);
               #1 req_valid[1] = 1'b0;
            end
         end
      end
      n_checks++;
      if (ngr !== 10) $display("FAIL rr_grant_count: got %0d expected 10", ngr);
      else n_pass++;
      req_valid = '0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_pressure();
      int n;
      logic [RW-1:0] exp;
      set_req(1, 4'd9, 4'd12, 1'b1);
      rsp_ready = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (req_ready[1]) break;
         n++;
      end
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      set_req(3, 4'd6, 4'd6, 1'b0);
      wait_rsp(n);
      exp = exp_rsp(1, 4'd9, 4'd12, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || got_rsp() !== exp)
            $display("FAIL bp_hold_%0d: got valid=%b data=%h expected 1/%h", k, rsp_valid, got_rsp(), exp);
         else n_pass++;
         n_checks++;
         if (req_ready !== '0) $display("FAIL bp_no_grant_%0d: got %b expected 0000", k, req_ready);
         else n_pass++;
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b1)
         $display("FAIL bp_release_cycle: got ready=%b valid=%b expected 0000/1", req_ready, rsp_valid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b1000 || rsp_valid !== 1'b0)
         $display("FAIL bp_next_grant: got ready=%b valid=%b expected 1000/0", req_ready, rsp_valid);
      else n_pass++;
      @(posedge clk);
      #1 req_valid[3] = 1'b0;
      wait_rsp(n);
      exp = exp_rsp(3, 4'd6, 4'd6, 1'b0);
      n_checks++;
      if (rsp_valid !== 1'b1 || got_rsp() !== exp) $display("FAIL bp_second_rsp: got %h expected %h", got_rsp(), exp);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_in_exec();
      int n;
      logic [RW-1:0] exp;
      set_req(1, 4'd2, 4'd2, 1'b0);
      rsp_ready = 1'b1;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (req_ready[1]) break;
         n++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      set_req(1, 4'd11, 4'd4, 1'b1);
      set_req(3, 4'd4, 4'd13, 1'b0);
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0) $display("FAIL rst_exec_ready: got %b expected 0000", req_ready);
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL rst_exec_no_rsp: got %b expected 0", rsp_valid);
      else n_pass++;
      n_checks++;
      if (req_ready !== 4'b0010) $display("FAIL rst_exec_first_grant: got %b expected 0010", req_ready);
      else n_pass++;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      wait_rsp(n);
      exp = exp_rsp(1, 4'd11, 4'd4, 1'b1);
      n_checks++;
      if (rsp_valid !== 1'b1 || got_rsp() !== exp) $display("FAIL rst_exec_rsp1: got %h expected %h", got_rsp(), exp);
      else n_pass++;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b1000) $display("FAIL rst_exec_second_grant: got %b expected 1000", req_ready);
      else n_pass++;
      @(posedge clk);
      #1 req_valid[3] = 1'b0;
      wait_rsp(n);
      exp = exp_rsp(3, 4'd4, 4'd13, 1'b0);
      n_checks++;
      if (rsp_valid !== 1'b1 || got_rsp() !== exp) $display("FAIL rst_exec_rsp3: got %h expected %h", got_rsp(), exp);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int w, l, i;
      logic [3:0] a, b;
      logic m;
      logic [RW-1:0] res, exp;
      for (int k = 0; k < 40; k++) begin
         i = $urandom_range(0, NREQ-1);
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         m = 1'($urandom_range(0, 1));
         do_op(i, a, b, m, w, l, res);
         exp = exp_rsp(i, a, b, m);
         n_checks++;
         if (res !== exp || l !== 2)
            $display("FAIL random_%0d: got %h lat %0d expected %h lat 2 (a=%0d b=%0d m=%0d)", k, res, l, exp, a, b, m);
         else n_pass++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_m     = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_wrap();
      test_round_robin();
      test_back_pressure();
      test_reset_in_exec();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit adder/subtractor datapath between NREQ requesters.
- Each requester presents operands a and b plus mode m (0 = add, 1 = subtract, computed as a + ~b + 1) on a valid/ready request channel.
- The block grants one request, executes it on the shared unit, and returns the result on a single tagged response channel with back-pressure.
- It instantiates the existing addersubtractor unit as its only arithmetic resource and sits between the requesting control blocks and that unit.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept; at most one bit high.
- req_a  input  4*NREQ  operand a; requester i uses bits [4i+3:4i].
- req_b  input  4*NREQ  operand b; same packing as req_a.
- req_m  input  NREQ  mode per requester: 0 = add, 1 = subtract.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by the consumer.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_r  output  4  4-bit result.
- rsp_c  output  1  carry-out; for subtract, 1 = no borrow (a >= b unsigned).
- rsp_ovf  output  1  signed two's-complement overflow.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst=1 at clk edge):
  - state=IDLE, rr_ptr=0.
  - Operand registers, rsp_id, rsp_r, rsp_c, rsp_ovf all cleared to 0.
  - rsp_valid=0; req_ready all 0 while rst=1.
- IDLE:
  - Winner g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g] is driven combinationally high in the same cycle. The transfer occurs on that edge.
  - On transfer: latch a_q=req_a[g], b_q=req_b[g], m_q=req_m[g], id_q=g; rr_ptr <= (g+1) mod NREQ; go to EXEC.
  - No req_valid high: stay in IDLE, rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - The shared unit operates on a_q, b_q, m_q.
  - Register rsp_r=s, rsp_c=carry-out, rsp_ovf=(a_q[3]==bb[3]) && (s[3]!=a_q[3]), where bb = m_q ? ~b_q : b_q.
  - rsp_id=id_q. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_r, rsp_c and rsp_ovf are held stable.
  - rsp_ready=1: transfer completes; go to IDLE.
  - rsp_ready=0: hold indefinitely.
- req_ready is 0 in EXEC and RESP. Requesters hold valid and operands until granted; req_valid must not depend on req_ready.
- Latency: grant edge to rsp_valid high = 2 cycles. Max throughput: 1 op per 3 cycles with rsp_ready tied high.
- Fairness: a continuously-valid requester is granted within NREQ grants.
- Arithmetic wraps modulo 16; there is no saturation.
- A requester dropping valid before grant is legal; the request is lost and not reported.
- Bits of req_valid at index >= NREQ do not exist. rr_ptr never exceeds NREQ-1.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded with no response. rsp_valid drops in the cycle after the reset edge and rr_ptr returns to 0.
- Simultaneous rsp_ready and new req_valid in RESP: the response completes. The new request is arbitrated in the following IDLE cycle, not in the same cycle.

Test Plan:
- Add: reset, req0 a=5 b=3 m=0 -> req_ready[0] in the first IDLE cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_r=8, rsp_c=0, rsp_ovf=1.
- Subtract: req2 a=5 b=3 m=1 -> rsp_id=2, r=2, c=1, ovf=0. Then a=3 b=5 m=1 -> r=14 (4'hE), c=0, ovf=0. Then a=8 b=1 m=1 -> r=7, c=1, ovf=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0, each 3 cycles apart; then drop req1 -> order skips 1 (…,3,0,2,3,0,…).
- Back-pressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid and data stable; req_ready all 0; no new grant until 1 cycle after rsp_ready=1.
- Reset in EXEC: grant req1, assert rst in the EXEC cycle -> no response; after reset, with req1 and req3 both valid, req1 is granted first (rr_ptr=0).
- Wrap: a=15 b=1 m=0 -> r=0, c=1, ovf=0. a=7 b=1 m=0 -> r=8, c=0, ovf=1.
